// File: rtl/vending_machine_change.sv
// Vending controller with configurable price and greedy change return.
// Accepts nickels, dimes and quarters, vends once the price is reached and
// pays back any remaining credit as dimes first, then a final nickel.
// A cancel request reuses the same change path to refund the whole credit.

module vending_machine_change #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 100,
    parameter int CREDIT_W   = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                cancel,
    output logic                open,
    output logic                ret_nickel,
    output logic                ret_dime,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    // Sum width has one spare bit so credit plus the largest coin never wraps.
    localparam int SUM_W = CREDIT_W + 1;

    localparam logic [SUM_W-1:0]    PriceSum  = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0]    MaxSum    = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]    Nickel    = SUM_W'(5);
    localparam logic [SUM_W-1:0]    Dime      = SUM_W'(10);
    localparam logic [SUM_W-1:0]    Quarter   = SUM_W'(25);
    localparam logic [CREDIT_W-1:0] FiveCr    = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TenCr     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] ZeroCr    = '0;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic                reject_d;

    logic                open_q;
    logic                ret_nickel_q;
    logic                ret_dime_q;
    logic                coin_reject_q;
    logic                busy_q;

    logic                coinPresent;
    logic [SUM_W-1:0]    coinValue;
    logic [SUM_W-1:0]    sum;

    // Pick the single coin that counts this edge: the most valuable one wins.
    always_comb begin
        coinPresent = N | D | Q;
        coinValue   = '0;
        if (Q) begin
            coinValue = Quarter;
        end else if (D) begin
            coinValue = Dime;
        end else if (N) begin
            coinValue = Nickel;
        end
        sum = {1'b0, credit_q} + coinValue;
    end

    // Next-state and next-credit decision for collect, vend and change phases.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            COLLECT: begin
                if (cancel) begin
                    reject_d = coinPresent;
                    if (credit_q != ZeroCr) begin
                        state_d = CHANGE;
                    end
                end else if (coinPresent) begin
                    if (sum > MaxSum) begin
                        reject_d = 1'b1;
                    end else if (sum >= PriceSum) begin
                        credit_d = CREDIT_W'(sum - PriceSum);
                        state_d  = VEND;
                    end else begin
                        credit_d = CREDIT_W'(sum);
                    end
                end
            end
            VEND: begin
                reject_d = coinPresent;
                if (credit_q != ZeroCr) begin
                    state_d = CHANGE;
                end else begin
                    state_d = COLLECT;
                end
            end
            CHANGE: begin
                reject_d = coinPresent;
                if (credit_q >= TenCr) begin
                    credit_d = credit_q - TenCr;
                end else if (credit_q >= FiveCr) begin
                    credit_d = credit_q - FiveCr;
                end else begin
                    credit_d = ZeroCr;
                end
                if (credit_d == ZeroCr) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = ZeroCr;
            end
        endcase
    end

    // State, credit and all outputs are registered; outputs follow the state being entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= COLLECT;
            credit_q      <= ZeroCr;
            open_q        <= 1'b0;
            ret_nickel_q  <= 1'b0;
            ret_dime_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            open_q        <= (state_d == VEND);
            busy_q        <= (state_d != COLLECT);
            ret_dime_q    <= (state_d == CHANGE) && (credit_d >= TenCr);
            ret_nickel_q  <= (state_d == CHANGE) && (credit_d < TenCr) && (credit_d >= FiveCr);
            coin_reject_q <= reject_d;
        end
    end

    assign open        = open_q;
    assign ret_nickel  = ret_nickel_q;
    assign ret_dime    = ret_dime_q;
    assign coin_reject = coin_reject_q;
    assign busy        = busy_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_vending_machine_change.sv
// Bench for vending_machine_change: two instances (price 15 and price 100)
// share the same coin/cancel inputs and are compared every cycle against a
// frame-queue reference model built from the vending rules.

module tb_vending_machine_change;

    logic       clk;
    logic       rstn;
    logic       N;
    logic       D;
    logic       Q;
    logic       cancel;

    logic       openA, retNickelA, retDimeA, coinRejectA, busyA;
    logic [7:0] creditA;
    logic       openB, retNickelB, retDimeB, coinRejectB, busyB;
    logic [7:0] creditB;

    int total;
    int bad;

    // One cycle of visible outputs as the model expects them.
    typedef struct {
        bit op;
        bit rd;
        bit rn;
        int cr;
    } frame_t;

    frame_t fq [2][32];
    int     head [2];
    int     tail [2];
    frame_t cur [2];
    bit     expRej [2];
    int     priceOf [2];
    int     maxOf [2];

    vending_machine_change #(.PRICE(15), .MAX_CREDIT(100), .CREDIT_W(8)) dutA (
        .clk(clk), .rstn(rstn), .N(N), .D(D), .Q(Q), .cancel(cancel),
        .open(openA), .ret_nickel(retNickelA), .ret_dime(retDimeA),
        .coin_reject(coinRejectA), .busy(busyA), .credit(creditA)
    );

    vending_machine_change #(.PRICE(100), .MAX_CREDIT(100), .CREDIT_W(8)) dutB (
        .clk(clk), .rstn(rstn), .N(N), .D(D), .Q(Q), .cancel(cancel),
        .open(openB), .ret_nickel(retNickelB), .ret_dime(retDimeB),
        .coin_reject(coinRejectB), .busy(busyB), .credit(creditB)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit isBusy(frame_t f);
        return f.op | f.rd | f.rn;
    endfunction

    task automatic pushFrame(int k, bit op, bit rd, bit rn, int cr);
        if (tail[k] < 32) begin
            fq[k][tail[k]] = '{op, rd, rn, cr};
            tail[k]++;
        end
    endtask

    task automatic popFrame(int k);
        if (head[k] < tail[k]) begin
            cur[k] = fq[k][head[k]];
            head[k]++;
        end else begin
            cur[k] = '{1'b0, 1'b0, 1'b0, 0};
        end
    endtask

    // Greedy payout: one dime per cycle while 10 or more remains, then a nickel.
    task automatic pushChange(int k, int c);
        int rem;
        rem = c;
        while (rem > 0) begin
            if (rem >= 10) begin
                pushFrame(k, 1'b0, 1'b1, 1'b0, rem);
                rem -= 10;
            end else begin
                pushFrame(k, 1'b0, 1'b0, 1'b1, rem);
                rem -= 5;
            end
        end
    endtask

    task automatic modelReset(int k);
        cur[k]    = '{1'b0, 1'b0, 1'b0, 0};
        head[k]   = 0;
        tail[k]   = 0;
        expRej[k] = 1'b0;
    endtask

    // Advance instance k's model by one clock edge with the given inputs.
    task automatic modelEdge(int k, bit n, bit d, bit q, bit c);
        int v;
        int s;
        v = q ? 25 : (d ? 10 : (n ? 5 : 0));
        expRej[k] = 1'b0;
        if (isBusy(cur[k])) begin
            expRej[k] = (v != 0);
            popFrame(k);
        end else if (c) begin
            expRej[k] = (v != 0);
            if (cur[k].cr > 0) begin
                head[k] = 0;
                tail[k] = 0;
                pushChange(k, cur[k].cr);
                popFrame(k);
            end
        end else if (v != 0) begin
            s = cur[k].cr + v;
            if (s > maxOf[k]) begin
                expRej[k] = 1'b1;
            end else if (s >= priceOf[k]) begin
                head[k] = 0;
                tail[k] = 0;
                pushFrame(k, 1'b1, 1'b0, 1'b0, s - priceOf[k]);
                pushChange(k, s - priceOf[k]);
                popFrame(k);
            end else begin
                cur[k].cr = s;
            end
        end
    endtask

    task automatic check(string tag, string sig, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, sig, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        check({tag, "/A"}, "open",        32'(openA),       32'(cur[0].op));
        check({tag, "/A"}, "ret_dime",    32'(retDimeA),    32'(cur[0].rd));
        check({tag, "/A"}, "ret_nickel",  32'(retNickelA),  32'(cur[0].rn));
        check({tag, "/A"}, "coin_reject", 32'(coinRejectA), 32'(expRej[0]));
        check({tag, "/A"}, "busy",        32'(busyA),       32'(isBusy(cur[0])));
        check({tag, "/A"}, "credit",      32'(creditA),     32'(cur[0].cr));
        check({tag, "/B"}, "open",        32'(openB),       32'(cur[1].op));
        check({tag, "/B"}, "ret_dime",    32'(retDimeB),    32'(cur[1].rd));
        check({tag, "/B"}, "ret_nickel",  32'(retNickelB),  32'(cur[1].rn));
        check({tag, "/B"}, "coin_reject", 32'(coinRejectB), 32'(expRej[1]));
        check({tag, "/B"}, "busy",        32'(busyB),       32'(isBusy(cur[1])));
        check({tag, "/B"}, "credit",      32'(creditB),     32'(cur[1].cr));
    endtask

    // Drive one edge's worth of inputs, update the model, check just after the edge.
    task automatic applyStimulus(string tag, bit n, bit d, bit q, bit c);
        N      = n;
        D      = d;
        Q      = q;
        cancel = c;
        @(posedge clk);
        modelEdge(0, n, d, q, c);
        modelEdge(1, n, d, q, c);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    task automatic idle(string tag, int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Directed scenarios first, then a randomized soak; all expectations come from the model.
    initial begin
        int r;
        bit rn, rd, rq, rc;
        total      = 0;
        bad        = 0;
        priceOf[0] = 15;
        maxOf[0]   = 100;
        priceOf[1] = 100;
        maxOf[1]   = 100;
        N = 1'b0; D = 1'b0; Q = 1'b0; cancel = 1'b0;
        rstn = 1'b0;
        modelReset(0);
        modelReset(1);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rstn = 1'b1;

        applyStimulus("nnn1", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("nnn2", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("nnn3", 1'b1, 1'b0, 1'b0, 1'b0);
        check("nnn3", "openA_direct", 32'(openA), 32'd1);
        idle("nnn_after", 2);

        applyStimulus("q_vend", 1'b0, 1'b0, 1'b1, 1'b0);
        check("q_vend", "creditA_direct", 32'(creditA), 32'd10);
        applyStimulus("q_dime", 1'b0, 1'b0, 1'b0, 1'b0);
        check("q_dime", "retDimeA_direct", 32'(retDimeA), 32'd1);
        idle("q_after", 2);

        applyStimulus("dq_d", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("dq_q", 1'b0, 1'b0, 1'b1, 1'b0);
        idle("dq_change", 4);

        applyStimulus("cancel_d", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("cancel_n", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("cancel", 1'b0, 1'b0, 1'b0, 1'b1);
        idle("cancel_refund", 3);
        applyStimulus("dq_same", 1'b0, 1'b1, 1'b1, 1'b0);
        idle("dq_same_after", 3);
        applyStimulus("cancel_zero", 1'b1, 1'b0, 1'b0, 1'b1);
        idle("cancel_zero_after", 1);

        rstn = 1'b0;
        modelReset(0);
        modelReset(1);
        #1;
        checkOutput("reset2");
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus("p100_q1", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("p100_q2", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("p100_q3", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("p100_d1", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("p100_d2", 1'b0, 1'b1, 1'b0, 1'b0);
        check("p100_d2", "creditB_direct", 32'(creditB), 32'd95);
        applyStimulus("p100_qrej", 1'b0, 1'b0, 1'b1, 1'b0);
        check("p100_qrej", "coinRejectB_direct", 32'(coinRejectB), 32'd1);
        applyStimulus("p100_n", 1'b1, 1'b0, 1'b0, 1'b0);
        check("p100_n", "openB_direct", 32'(openB), 32'd1);
        idle("p100_after", 3);

        rstn = 1'b0;
        modelReset(0);
        modelReset(1);
        #1;
        checkOutput("reset3");
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus("busy_d", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("busy_q", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("busy_coin1", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus("busy_coin2", 1'b0, 1'b1, 1'b0, 1'b0);
        check("busy_coin2", "retDimeA_direct", 32'(retDimeA), 32'd1);
        rstn = 1'b0;
        modelReset(0);
        modelReset(1);
        #1;
        checkOutput("reset_mid_change");
        @(negedge clk);
        rstn = 1'b1;
        idle("post_reset", 2);

        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            rn = (r < 15) || (r >= 37 && r < 41);
            rd = (r >= 15 && r < 27) || (r >= 37 && r < 41);
            rq = (r >= 27 && r < 41);
            rc = ($urandom_range(0, 19) == 0);
            applyStimulus("rand", rn, rd, rq, rc);
        end
        idle("drain", 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
